// File: rtl/mem_store_responder.sv
// mem_store_responder
//   Memory-side responder for the multicycle CPU's load/store requests.
//   Word, halfword and byte accesses against a synchronous word memory with
//   MEM_LAT cycles of read latency. Subword stores are read-modify-write.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_write              1 = store, 0 = load
//   req_size               00 word, 01 half, 10 byte, 11 reserved
//   req_addr, req_wdata    byte address, right-aligned store data
//   rsp_valid/rsp_ready    response handshake (valid held until ready)
//   rsp_rdata, rsp_err     zero-extended load data, misaligned/reserved flag
//   mem_addr, mem_wr       word-aligned memory address, one-cycle write strobe
//   mem_wdata, mem_rdata   memory write / read data
module mem_store_responder #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] lat_cnt;
  logic             op_write;
  logic [1:0]       op_size;
  logic [1:0]       op_lane;
  logic [31:0]      op_wdata;

  logic             accept;
  logic             req_bad;
  logic             rd_done;
  logic [4:0]       lane_shift;
  logic [31:0]      rd_shifted;
  logic [31:0]      load_data;
  logic [31:0]      lane_mask;
  logic [31:0]      merged;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign mem_wr    = (state == S_WR);

  assign accept  = (state == S_IDLE) && req_valid;
  assign rd_done = (state == S_RD) && (lat_cnt == LAT_LAST);

  always_comb begin
    req_bad = (req_size == 2'b11)
           || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
           || ((req_size == SZ_HALF) && req_addr[0]);
  end

  // Lane handling works on the live memory word during the capture cycle,
  // so no separate copy of the read word is kept.
  always_comb begin
    lane_shift = {op_lane, 3'b000};
    rd_shifted = mem_rdata >> lane_shift;
    load_data  = mem_rdata;
    lane_mask  = '1;
    case (op_size)
      SZ_HALF: begin
        load_data = {16'h0000, rd_shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_shift;
      end
      SZ_BYTE: begin
        load_data = {24'h00_0000, rd_shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_shift;
      end
      default: begin
        load_data = mem_rdata;
        lane_mask = '1;
      end
    endcase
    merged = (mem_rdata & ~lane_mask) | ((op_wdata << lane_shift) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad)                                 state_nxt = S_RESP;
          else if (req_write && (req_size == SZ_WORD)) state_nxt = S_WR;
          else                                         state_nxt = S_RD;
        end
      end
      S_RD: begin
        if (rd_done) state_nxt = op_write ? S_WR : S_RESP;
      end
      S_WR:   state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt   <= '0;
      op_write  <= 1'b0;
      op_size   <= '0;
      op_lane   <= '0;
      op_wdata  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        op_write  <= req_write;
        op_size   <= req_size;
        op_lane   <= req_addr[1:0];
        op_wdata  <= req_wdata;
        lat_cnt   <= '0;
        rsp_rdata <= '0;
        rsp_err   <= req_bad;
        // A rejected request never touches the memory-side outputs.
        if (!req_bad) begin
          mem_addr <= {req_addr[31:2], 2'b00};
          if (req_write && (req_size == SZ_WORD)) mem_wdata <= req_wdata;
        end
      end
      if (state == S_RD) begin
        if (rd_done) begin
          if (op_write) mem_wdata <= merged;
          else          rsp_rdata <= load_data;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_store_responder.sv
module tb_mem_store_responder;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] mem_addr  [2];
  logic        mem_wr    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  mem_store_responder #(.MEM_LAT(LAT0)) u_dut_l1 (
    .clk(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_store_responder #(.MEM_LAT(LAT1)) u_dut_l3 (
    .clk(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Synchronous memories (16 words each) with fixed read latency.
  logic [31:0] mem     [2][16];
  logic [31:0] pipe    [2][3];
  logic        mem_init;

  function automatic logic [31:0] init_word(int d, int k);
    return (32'h9E3779B9 * 32'(k + 1)) ^ ((d == 1) ? 32'h5A5A0000 : 32'h0000A5A5);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_init) begin
        for (int k = 0; k < 16; k++) mem[d][k] <= init_word(d, k);
      end else if (mem_wr[d]) begin
        mem[d][mem_addr[d][5:2]] <= mem_wdata[d];
      end
      pipe[d][0] <= mem[d][mem_addr[d][5:2]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end

  assign mem_rdata[0] = pipe[0][LAT0-1];
  assign mem_rdata[1] = pipe[1][LAT1-1];

  // Reference model state and expectations for the transaction in flight.
  logic [31:0] ref_mem [2][16];
  bit          active  [2];
  int          cyc     [2];
  bit          en_chk;
  bit          e_err     [2];
  logic [31:0] e_rdata   [2];
  logic [31:0] e_wdata   [2];
  logic [31:0] e_addr    [2];
  int          e_wr_cyc  [2];
  int          e_rsp_cyc [2];
  int          e_rd_last [2];
  int          first_rsp [2];
  int          seen_wr   [2];
  int          acc_wait  [2];
  logic [31:0] last_rdata [2];
  logic        last_err   [2];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int lat_of(int d);
    return (d == 1) ? LAT1 : LAT0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic txn_t mk(logic wr, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
    txn_t t;
    t.wr = wr; t.sz = sz; t.a = a; t.wd = wd;
    return t;
  endfunction

  // Behaviour from the access rules: lane position, width mask, latency table.
  task automatic predict(input int d, input txn_t t, output bit err, output logic [31:0] rdata,
                         output logic [31:0] new_word, output int wr_cyc, output int rsp_cyc,
                         output int rd_last);
    int L;
    int sh;
    int nb;
    logic [63:0] m;
    logic [31:0] mask;
    logic [31:0] word;
    L    = lat_of(d);
    sh   = 8 * int'(t.a[1:0]);
    nb   = (t.sz == 2'd0) ? 4 : (t.sz == 2'd1) ? 2 : 1;
    m    = (64'd1 << (8 * nb)) - 64'd1;
    mask = m[31:0] << sh;
    word = ref_mem[d][t.a[5:2]];
    err  = (t.sz == 2'd3) || (t.sz == 2'd0 && t.a[1:0] != 2'd0) || (t.sz == 2'd1 && t.a[0]);
    rdata    = (!err && !t.wr) ? ((word >> sh) & m[31:0]) : 32'h0;
    new_word = (word & ~mask) | ((t.wd << sh) & mask);
    if (err)                 begin wr_cyc = 0;     rsp_cyc = 1;     rd_last = 0;     end
    else if (t.wr && nb == 4) begin wr_cyc = 1;     rsp_cyc = 2;     rd_last = 0;     end
    else if (!t.wr)          begin wr_cyc = 0;     rsp_cyc = L + 2; rd_last = L + 1; end
    else                     begin wr_cyc = L + 2; rsp_cyc = L + 3; rd_last = L + 1; end
  endtask

  always @(negedge clk) begin
    if (en_chk) begin
      for (int d = 0; d < 2; d++) begin
        string p;
        p = $sformatf("L%0d", lat_of(d));
        if (active[d]) begin
          chk({p, " busy req_ready"}, 32'(req_ready[d]), 32'd0);
          chk({p, " mem_wr"}, 32'(mem_wr[d]), 32'(cyc[d] == e_wr_cyc[d]));
          if (cyc[d] == e_wr_cyc[d]) begin
            chk({p, " wr mem_addr"}, mem_addr[d], e_addr[d]);
            chk({p, " wr mem_wdata"}, mem_wdata[d], e_wdata[d]);
          end
          if (cyc[d] <= e_rd_last[d]) chk({p, " rd mem_addr"}, mem_addr[d], e_addr[d]);
          chk({p, " rsp_valid"}, 32'(rsp_valid[d]), 32'(cyc[d] >= e_rsp_cyc[d]));
          if (cyc[d] >= e_rsp_cyc[d]) begin
            chk({p, " rsp_rdata"}, rsp_rdata[d], e_rdata[d]);
            chk({p, " rsp_err"}, 32'(rsp_err[d]), 32'(e_err[d]));
          end
        end else begin
          chk({p, " idle req_ready"}, 32'(req_ready[d]), 32'd1);
          chk({p, " idle mem_wr"}, 32'(mem_wr[d]), 32'd0);
          chk({p, " idle rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
        end
      end
    end
  end

  // Presents t and waits for the accepting edge; returns at that edge with
  // expectations loaded and the model memory updated (if commit).
  task automatic accept_req(input int d, input txn_t t, input bit commit, output bit ok);
    bit err;
    logic [31:0] rd, nw;
    int wc, rc, rl;
    bit r;
    predict(d, t, err, rd, nw, wc, rc, rl);
    req_valid[d] = 1'b1; req_write[d] = t.wr; req_size[d] = t.sz;
    req_addr[d] = t.a; req_wdata[d] = t.wd; rsp_ready[d] = 1'b0;
    acc_wait[d] = 0;
    ok = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(negedge clk);
      r = req_ready[d];
      @(posedge clk);
      if (r) ok = 1'b1;
      else   acc_wait[d]++;
    end
    if (!ok) begin
      fail_now($sformatf("L%0d accept", lat_of(d)));
      #1 req_valid[d] = 1'b0;
      return;
    end
    e_err[d] = err; e_rdata[d] = rd; e_wdata[d] = t.wr ? nw : 32'h0;
    e_addr[d] = {t.a[31:2], 2'b00};
    e_wr_cyc[d] = wc; e_rsp_cyc[d] = rc; e_rd_last[d] = rl;
    first_rsp[d] = 0; seen_wr[d] = 0;
    cyc[d] = 1; active[d] = 1'b1;
    if (commit && !err && t.wr) ref_mem[d][t.a[5:2]] = nw;
  endtask

  task automatic run_txn(input int d, input txn_t t, input int hold, input bit b2b, input txn_t nx);
    bit ok, done, hs;
    int n;
    accept_req(d, t, 1'b1, ok);
    if (!ok) return;
    #1;
    // Request inputs must be ignored while busy: scramble them.
    req_valid[d] = 1'($urandom); req_write[d] = 1'($urandom); req_size[d] = 2'($urandom);
    req_addr[d] = $urandom; req_wdata[d] = $urandom;
    done = 1'b0;
    n = 0;
    while (!done) begin
      if (mem_wr[d]) seen_wr[d] = cyc[d];
      if (rsp_valid[d] && first_rsp[d] == 0) first_rsp[d] = cyc[d];
      if (rsp_valid[d] && (cyc[d] - first_rsp[d]) >= hold) begin
        rsp_ready[d] = 1'b1;
        if (b2b) begin
          req_valid[d] = 1'b1; req_write[d] = nx.wr; req_size[d] = nx.sz;
          req_addr[d] = nx.a; req_wdata[d] = nx.wd;
        end else begin
          req_valid[d] = 1'b0;
        end
      end else begin
        rsp_ready[d] = 1'b0;
      end
      hs = rsp_valid[d] && rsp_ready[d];
      if (hs) begin
        last_rdata[d] = rsp_rdata[d];
        last_err[d]   = rsp_err[d];
      end
      @(posedge clk);
      if (hs) begin
        active[d] = 1'b0;
        done = 1'b1;
      end else begin
        cyc[d]++;
      end
      #1;
      rsp_ready[d] = 1'b0;
      n++;
      if (!done && n > 40) begin
        fail_now($sformatf("L%0d response", lat_of(d)));
        active[d] = 1'b0;
        req_valid[d] = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_vals(input int d);
    string p;
    p = $sformatf("L%0d reset", lat_of(d));
    chk({p, " req_ready"}, 32'(req_ready[d]), 32'd1);
    chk({p, " rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({p, " rsp_err"}, 32'(rsp_err[d]), 32'd0);
    chk({p, " rsp_rdata"}, rsp_rdata[d], 32'h0);
    chk({p, " mem_wr"}, 32'(mem_wr[d]), 32'd0);
    chk({p, " mem_addr"}, mem_addr[d], 32'h0);
    chk({p, " mem_wdata"}, mem_wdata[d], 32'h0);
  endtask

  task automatic reset_mid(input int d, input txn_t t);
    bit ok;
    accept_req(d, t, 1'b0, ok);
    if (!ok) return;
    #1;
    req_valid[d] = 1'b0;
    rst[d] = 1'b1;
    @(posedge clk);
    active[d] = 1'b0;
    #1;
    rst[d] = 1'b0;
    chk_reset_vals(d);
    repeat (6) @(posedge clk);
    #1;
  endtask

  function automatic txn_t gen();
    txn_t t;
    int r;
    r = $urandom_range(0, 7);
    t.wr = 1'($urandom);
    t.sz = (r == 7) ? 2'd3 : 2'(r % 3);
    t.a  = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (t.sz == 2'd0) t.a[1:0] = 2'b00;
      if (t.sz == 2'd1) t.a[0] = 1'b0;
    end
    t.wd = $urandom;
    return t;
  endfunction

  task automatic directed(input int d);
    string p;
    int L;
    txn_t t, ld;
    bit err;
    logic [31:0] rd, nw;
    int wc, rc, rl;
    L = lat_of(d);
    p = $sformatf("L%0d", L);

    t = mk(1'b1, 2'd0, 32'h10, 32'hDEADBEEF);
    run_txn(d, t, 0, 1'b0, t);
    chk({p, " wstore rsp cyc"}, 32'(first_rsp[d]), 32'd2);
    chk({p, " wstore wr cyc"}, 32'(seen_wr[d]), 32'd1);
    chk({p, " wstore mem"}, mem[d][4], 32'hDEADBEEF);

    t = mk(1'b1, 2'd0, 32'h10, 32'h11223344);
    run_txn(d, t, 0, 1'b0, t);
    t = mk(1'b1, 2'd2, 32'h13, 32'h000000AA);
    predict(d, t, err, rd, nw, wc, rc, rl);
    chk({p, " model byte merge"}, nw, 32'hAA223344);
    run_txn(d, t, 0, 1'b0, t);
    chk({p, " bstore wr cyc"}, 32'(seen_wr[d]), 32'(L + 2));
    chk({p, " bstore rsp cyc"}, 32'(first_rsp[d]), 32'(L + 3));
    chk({p, " bstore mem"}, mem[d][4], 32'hAA223344);
    chk({p, " bstore rdata"}, last_rdata[d], 32'h0);

    t = mk(1'b1, 2'd0, 32'h10, 32'h8001FFFF);
    run_txn(d, t, 0, 1'b0, t);
    t = mk(1'b0, 2'd1, 32'h12, 32'h0BADF00D);
    run_txn(d, t, 0, 1'b0, t);
    chk({p, " hload rdata"}, last_rdata[d], 32'h00008001);
    chk({p, " hload err"}, 32'(last_err[d]), 32'd0);
    chk({p, " hload rsp cyc"}, 32'(first_rsp[d]), 32'(L + 2));

    t = mk(1'b1, 2'd1, 32'h11, 32'h00001234);
    run_txn(d, t, 0, 1'b0, t);
    chk({p, " misaligned err"}, 32'(last_err[d]), 32'd1);
    chk({p, " misaligned rsp cyc"}, 32'(first_rsp[d]), 32'd1);
    chk({p, " misaligned no wr"}, 32'(seen_wr[d]), 32'd0);
    chk({p, " misaligned mem"}, mem[d][4], 32'h8001FFFF);

    t  = mk(1'b1, 2'd2, 32'h10, 32'h00000055);
    ld = mk(1'b0, 2'd0, 32'h10, 32'h0);
    run_txn(d, t, 5, 1'b1, ld);
    chk({p, " held bstore rsp cyc"}, 32'(first_rsp[d]), 32'(L + 3));
    run_txn(d, ld, 0, 1'b0, ld);
    chk({p, " b2b accept wait"}, 32'(acc_wait[d]), 32'd0);
    chk({p, " b2b load rdata"}, last_rdata[d], 32'h8001FF55);
    chk({p, " b2b load rsp cyc"}, 32'(first_rsp[d]), 32'(L + 2));

    reset_mid(d, mk(1'b1, 2'd2, 32'h12, 32'h00000077));
    chk({p, " aborted rmw mem"}, mem[d][4], 32'h8001FF55);
  endtask

  task automatic random_run(input int d);
    txn_t list [100];
    for (int i = 0; i < 100; i++) list[i] = gen();
    for (int i = 0; i < 100; i++) begin
      bit b2b;
      b2b = (i + 1 < 100) && ($urandom_range(0, 1) == 1);
      run_txn(d, list[i], $urandom_range(0, 3), b2b, (i + 1 < 100) ? list[i+1] : list[i]);
    end
    for (int k = 0; k < 16; k++)
      chk($sformatf("L%0d final mem[%0d]", lat_of(d), k), mem[d][k], ref_mem[d][k]);
  endtask

  initial begin
    en_chk = 1'b0;
    mem_init = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
      active[d] = 1'b0; cyc[d] = 0;
      for (int k = 0; k < 16; k++) ref_mem[d][k] = init_word(d, k);
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    mem_init = 1'b0;
    en_chk = 1'b1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    for (int d = 0; d < 2; d++) begin
      directed(d);
      random_run(d);
    end
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
